fir_filter: RTL and testbench
=============================

// Module: fir_filter
// PURPOSE
//  64-tap, 16-bit signed FIR filter with a run-time loadable coefficient memory.
//  Single clock domain; each sample is processed by one time-multiplexed MAC over 64 cycles.
//  Sits between a sample source (one valid_in strobe per sample) and a consumer that reads
//  dout when valid_out pulses.
// PARAMETERS
//  NTAPS   64  number of taps / coefficient-memory depth
//  DATA_W  16  sample, coefficient and output width (signed two's complement)
//  ADDR_W  14  coefficient address port width; only the low log2(NTAPS) bits index memory
//  FRAC    15  fractional bits of coefficients (Q1.15); output = acc >>> FRAC
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  valid_in   in   1       sample strobe: data_in is a new input sample
//  data_in    in   16      sample (valid_in) or coefficient (w_en), signed
//  addr       in   14      coefficient index for writes
//  w_en       in   1       coefficient write enable
//  valid_out  out  1       one-cycle pulse: dout holds a new result
//  dout       out  16      filtered output, signed, saturated
// BEHAVIOUR
//  - Reset: coef[0..63]=0, delay line x[0..63]=0, acc=0, tap counter=0, busy=0,
//    dout=0, valid_out=0. Reset mid-computation aborts it; no valid_out follows.
//  - Coefficient write: w_en=1 and !busy and addr<64 -> coef[addr]<=data_in.
//    addr>=64 ignored. w_en while busy ignored (coefficients stable during a MAC run).
//  - Sample accept: valid_in=1 and !busy and w_en=0 -> shift x[k]<=x[k-1], x[0]<=data_in,
//    busy<=1, acc<=0, counter<=0. w_en and valid_in together: write wins, sample dropped.
//    valid_in while busy is dropped; sources space samples >= NTAPS+1 cycles.
//  - y = sum_{k=0..63} coef[k]*x[k]; x[0] newest. One product per cycle, k=0..63.
//  - Widths: 16x16 signed -> 32-bit product; accumulator 38 bits (32+6), no overflow.
//  - Output: acc >>> 15 (arithmetic, truncation toward -inf), saturated to
//    [0x8000,0x7FFF].
//  - Timing: sample accepted at edge T; MAC on edges T+1..T+64; dout registered and
//    valid_out=1 at edge T+65 (latency 65 cycles); valid_out low next cycle, busy=0.
//    A new sample is accepted from T+65 onward.
//  - dout holds its value between results; valid_out is never high two cycles in a row.
// STRUCTURE
//  - fir_pkg: NTAPS, DATA_W, COEF_W, ACC_W=38, FRAC, TAP_IDX_W=6 constants.
//  - Top: coefficient RAM (64x16 regs), delay-line shift register, control
//    (IDLE -> RUN(64 cycles) -> DONE(1 cycle) -> IDLE), output saturation.
//  - Sub-module fir_mac: registered signed 16x16 multiply + 38-bit accumulate
//    with clear/enable.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> dout=0x0000, valid_out=0; a sample of any value
//    then yields dout=0x0000 (all coefs 0).
//  2 Single tap: coef[0]=0x7FFF, rest 0; sample 0x4000 -> exactly 65 cycles later
//    valid_out=1, dout=0x3FFF.
//  3 Impulse response: coef[k]=0x0100*(k+1); sample 0x7FFF then 63 zeros ->
//    outputs 0x00FF,0x01FF,...,0x3FFF in order.
//  4 Saturation: all coefs 0x7FFF; 64 samples 0x7FFF -> 64th dout=0x7FFF;
//    then 64 samples 0x8000 -> dout=0x8000.
//  5 Drops: valid_in during busy, valid_in with w_en, w_en during busy, addr=64 ->
//    no state change; result count and values unchanged vs a clean run.
//  6 rst asserted at cycle 30 of a MAC run -> no valid_out; dout=0; next sample
//    computes from a zero delay line.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR constants, controller state encoding and output saturation helper
package fir_pkg;
  localparam int NTAPS = 64;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W = 38;
  localparam int FRAC = 15;
  localparam int TAP_IDX_W = 6;
  localparam int ADDR_W = 14;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    logic fits;
    s = acc >>> FRAC;
    fits = (&s[ACC_W-1:DATA_W-1]) || !(|s[ACC_W-1:DATA_W-1]);
    return fits ? s[DATA_W-1:0] : s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed 16x16 multiply accumulated into a 38-bit register with clear/enable (clk, rst, clr, en, a, b -> acc)
module fir_mac
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [DATA_W+COEF_W-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/fir_filter.sv
// fir_filter: 64-tap time-multiplexed FIR with loadable coefficients (clk, rst, valid_in, data_in, addr, w_en -> valid_out, dout)
module fir_filter
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w_en,
  output logic              valid_out,
  output logic [DATA_W-1:0] dout
);
  state_t state, state_nx;
  logic [TAP_IDX_W-1:0] cnt;
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [DATA_W-1:0] x [NTAPS];
  logic signed [ACC_W-1:0] acc;
  logic busy, wr, accept;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // DONE is not busy so a sample can arrive on the same edge the result is registered
  always_comb state_nx = accept ? RUN : (state == RUN) ? ((cnt == TAP_IDX_W'(NTAPS - 1)) ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    wr = w_en && !busy && (addr < ADDR_W'(NTAPS));
    accept = valid_in && !busy && !w_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      coef <= '{default: '0};
      x <= '{default: '0};
    end else begin
      if (wr) coef[addr[TAP_IDX_W-1:0]] <= data_in;
      if (accept) begin
        for (int i = NTAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= data_in;
        cnt <= '0;
      end else if (busy) cnt <= cnt + 1'b1;
    end
  end
  fir_mac u_mac (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (busy),
    .a  (x[cnt]),
    .b  (coef[cnt]),
    .acc(acc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      dout <= '0;
    end else begin
      valid_out <= state == DONE;
      if (state == DONE) dout <= saturate(acc);
    end
  end
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: randomized scoreboard bench for fir_filter against an arithmetic FIR model
module tb_fir_filter;
  logic clk = 0, rst = 1, valid_in = 0, w_en = 0, valid_out;
  logic [15:0] data_in = 0, dout;
  logic [13:0] addr = 0;
  int cyc = 0, errors = 0, checks = 0, busy_until = -1;
  typedef struct {logic [15:0] y; int due;} exp_t;
  exp_t q[$];
  logic signed [15:0] cm [64];
  logic signed [15:0] xm [64];

  fir_filter dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .addr(addr), .w_en(w_en), .valid_out(valid_out), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_y();
    longint s = 0;
    logic [63:0] r;
    for (int k = 0; k < 64; k++) s += longint'(cm[k]) * longint'(xm[k]);
    s = s >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    r = s;
    return r[15:0];
  endfunction

  task automatic step(input bit v, input bit w, input int a, input logic [15:0] d);
    int e;
    @(negedge clk);
    valid_in = v; w_en = w; addr = a[13:0]; data_in = d;
    e = cyc + 1;
    if (w) begin
      if (e > busy_until && a >= 0 && a < 64) cm[a] = d;
    end else if (v && e > busy_until) begin
      for (int k = 63; k > 0; k--) xm[k] = xm[k-1];
      xm[0] = d;
      q.push_back('{ref_y(), e + 65});
      busy_until = e + 64;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 16'h0);
  endtask

  task automatic sample(input logic [15:0] d);
    step(1, 0, 0, d);
    idle(64);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1; valid_in = 0; w_en = 0;
    repeat (n) @(negedge clk);
    for (int k = 0; k < 64; k++) begin cm[k] = 0; xm[k] = 0; end
    q.delete();
    busy_until = -1;
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_valid", 32'(valid_out), 32'h0);
    rst = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got valid_out=1 dout=%h expected no result (cycle %0d)", dout, cyc);
        end else begin
          e = q.pop_front();
          chk("dout", 32'(dout), 32'(e.y));
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        checks++; errors++;
        $display("FAIL missing_valid: got no valid_out expected result %h at cycle %0d", q[0].y, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int k = 0; k < 64; k++) begin cm[k] = 0; xm[k] = 0; end
    do_reset(2);
    sample(16'($urandom));
    step(0, 1, 0, 16'h7FFF);
    sample(16'h4000);
    do_reset(2);
    for (int k = 0; k < 64; k++) step(0, 1, k, 16'(256 * (k + 1)));
    sample(16'h7FFF);
    repeat (63) sample(16'h0000);
    for (int k = 0; k < 64; k++) step(0, 1, k, 16'h7FFF);
    repeat (64) sample(16'h7FFF);
    repeat (64) sample(16'h8000);
    for (int k = 0; k < 64; k++) step(0, 1, k, 16'($urandom));
    repeat (6) begin
      step(1, 0, 0, 16'($urandom));
      idle(10);
      step(1, 0, 0, 16'($urandom));
      step(0, 1, int'($urandom_range(0, 63)), 16'($urandom));
      step(1, 1, int'($urandom_range(0, 63)), 16'($urandom));
      idle(51);
      step(1, 1, 3, 16'($urandom));
      step(0, 1, 64, 16'($urandom));
      step(0, 1, 16320 + int'($urandom_range(0, 63)), 16'($urandom));
    end
    idle(2);
    step(1, 0, 0, 16'($urandom));
    idle(29);
    do_reset(1);
    idle(80);
    for (int k = 0; k < 64; k += 7) step(0, 1, k, 16'($urandom));
    sample(16'($urandom));
    sample(16'($urandom));
    for (int k = 0; k < 64; k++) step(0, 1, k, 16'($urandom_range(0, 4095)));
    repeat (10) sample(16'($urandom));
    idle(70);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
